de2i_150_qsys_avm_cmd_master: RTL and testbench

Single-outstanding Avalon-MM master inside the de2i_150_qsys fabric. It drives the register slaves (LED/echo register and peers) from a simple valid/ready command port, owned by the PCIe-side control logic. It issues one read or write at a time, honours waitrequest, collects readdata_valid, and returns one response per command with a timeout error flag.

---
 rtl/de2i_150_qsys_avm_pkg.sv | 15 +
 rtl/de2i_150_qsys_avm_cmd_master_if.sv | 41 ++++
 rtl/de2i_150_qsys_avm_timer.sv | 41 ++++
 rtl/de2i_150_qsys_avm_cmd_master.sv | 169 ++++++++++++++++
 tb/tb_de2i_150_qsys_avm_cmd_master.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/de2i_150_qsys_avm_pkg.sv
// Shared types and default widths for the de2i_150_qsys Avalon-MM command master.
package de2i_150_qsys_avm_pkg;

    localparam int unsigned AVM_ADDR_W  = 2;
    localparam int unsigned AVM_DATA_W  = 32;
    localparam int unsigned AVM_TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } avm_state_e;

endpackage

// File: rtl/de2i_150_qsys_avm_cmd_master_if.sv
// Command/response port plus Avalon-MM master port of the command master.
// master: the command master itself; slave: the command source and register slave side.
interface de2i_150_qsys_avm_cmd_master_if
    import de2i_150_qsys_avm_pkg::*;
#(
    parameter int unsigned ADDR_W = AVM_ADDR_W,
    parameter int unsigned DATA_W = AVM_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdata_valid;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdata_valid,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output avm_waitrequest, avm_readdata, avm_readdata_valid,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

endinterface

// File: rtl/de2i_150_qsys_avm_timer.sv
// Clear/enable saturating cycle counter with an expired flag; reusable by fabric masters.
module de2i_150_qsys_avm_timer
    import de2i_150_qsys_avm_pkg::*;
#(
    parameter int unsigned W     = AVM_TIMER_W,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, then count up until the limit and hold there.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < LIMIT_W)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q >= LIMIT_W);

endmodule

// File: rtl/de2i_150_qsys_avm_cmd_master.sv
// Single-outstanding Avalon-MM master driven by a valid/ready command port.
// Build option: DE2I_AVM_WRITE_ECHO_EN makes writes wait for an echoed readdata_valid.
module de2i_150_qsys_avm_cmd_master
    import de2i_150_qsys_avm_pkg::*;
#(
    parameter int unsigned ADDR_W  = AVM_ADDR_W,
    parameter int unsigned DATA_W  = AVM_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             reset_n,
    de2i_150_qsys_avm_cmd_master_if.master   bus
);

`ifdef DE2I_AVM_WRITE_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    avm_state_e        state_q, state_d;
    logic              is_write_q, is_write_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic              avm_chipselect_q, avm_chipselect_d;
    logic              avm_write_n_q, avm_write_n_d;
    logic              avm_read_n_q, avm_read_n_d;
    logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;

    logic timer_clr_c;
    logic timer_en_c;
    logic timer_expired_c;

    assign timer_en_c = (state_q == REQ) || (state_q == WAIT);

    de2i_150_qsys_avm_timer #(
        .W     (AVM_TIMER_W),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (timer_clr_c),
        .en        (timer_en_c),
        .expired_c (timer_expired_c)
    );

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_d          = state_q;
        is_write_d       = is_write_q;
        cmd_ready_d      = cmd_ready_q;
        rsp_valid_d      = 1'b0;
        rsp_data_d       = rsp_data_q;
        rsp_error_d      = rsp_error_q;
        avm_address_d    = avm_address_q;
        avm_chipselect_d = avm_chipselect_q;
        avm_write_n_d    = avm_write_n_q;
        avm_read_n_d     = avm_read_n_q;
        avm_writedata_d  = avm_writedata_q;
        timer_clr_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    is_write_d       = bus.cmd_write;
                    avm_address_d    = bus.cmd_address;
                    avm_writedata_d  = bus.cmd_writedata;
                    avm_chipselect_d = 1'b1;
                    avm_write_n_d    = ~bus.cmd_write;
                    avm_read_n_d     = bus.cmd_write;
                    cmd_ready_d      = 1'b0;
                    timer_clr_c      = 1'b1;
                    state_d          = REQ;
                end
            end
            REQ: begin
                if (timer_expired_c) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_n_d     = 1'b1;
                    rsp_valid_d      = 1'b1;
                    rsp_data_d       = '0;
                    rsp_error_d      = 1'b1;
                    state_d          = RSP;
                end else if (!bus.avm_waitrequest) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_n_d     = 1'b1;
                    if (is_write_q && !ECHO_EN) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b0;
                        state_d     = RSP;
                    end else if (bus.avm_readdata_valid) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.avm_readdata;
                        rsp_error_d = 1'b0;
                        state_d     = RSP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (timer_expired_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RSP;
                end else if (bus.avm_readdata_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.avm_readdata;
                    rsp_error_d = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            is_write_q       <= 1'b0;
            cmd_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_error_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_read_n_q     <= 1'b1;
            avm_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            is_write_q       <= is_write_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            rsp_error_q      <= rsp_error_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_read_n_q     <= avm_read_n_d;
            avm_writedata_q  <= avm_writedata_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_error      = rsp_error_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_chipselect = avm_chipselect_q;
    assign bus.avm_write_n    = avm_write_n_q;
    assign bus.avm_read_n     = avm_read_n_q;
    assign bus.avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_de2i_150_qsys_avm_cmd_master.sv
// Directed self-checking bench for de2i_150_qsys_avm_cmd_master (TIMEOUT = 8).
module tb_de2i_150_qsys_avm_cmd_master;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    de2i_150_qsys_avm_cmd_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

    de2i_150_qsys_avm_cmd_master #(
        .ADDR_W  (2),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in the current cycle; returns in the first REQ cycle.
    task automatic issue(input logic wr, input logic [1:0] addr, input logic [31:0] wd);
        chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = wr;
        bus.cmd_address   = addr;
        bus.cmd_writedata = wd;
        tick();
        bus.cmd_valid     = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.cmd_ready),      32'd1);
        chk({tag, "_rspv"},  32'(bus.rsp_valid),      32'd0);
        chk({tag, "_rspd"},  bus.rsp_data,            32'd0);
        chk({tag, "_rspe"},  32'(bus.rsp_error),      32'd0);
        chk({tag, "_cs"},    32'(bus.avm_chipselect), 32'd0);
        chk({tag, "_wrn"},   32'(bus.avm_write_n),    32'd1);
        chk({tag, "_rdn"},   32'(bus.avm_read_n),     32'd1);
        chk({tag, "_addr"},  32'(bus.avm_address),    32'd0);
        chk({tag, "_wdata"}, bus.avm_writedata,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        bus.cmd_valid          = 1'b0;
        bus.cmd_write          = 1'b0;
        bus.cmd_address        = 2'd0;
        bus.cmd_writedata      = 32'd0;
        bus.avm_waitrequest    = 1'b0;
        bus.avm_readdata       = 32'd0;
        bus.avm_readdata_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_values("rst");
        reset_n = 1'b1;
        tick();

        // Zero-wait write of 0xA5A5_0001 to address 0
        issue(1'b1, 2'd0, 32'hA5A5_0001);
        chk("wr_wrn",   32'(bus.avm_write_n),    32'd0);
        chk("wr_rdn",   32'(bus.avm_read_n),     32'd1);
        chk("wr_cs",    32'(bus.avm_chipselect), 32'd1);
        chk("wr_addr",  32'(bus.avm_address),    32'd0);
        chk("wr_wdata", bus.avm_writedata,       32'hA5A5_0001);
        chk("wr_ready", 32'(bus.cmd_ready),      32'd0);
        chk("wr_rspv0", 32'(bus.rsp_valid),      32'd0);
        tick();
        chk("wr_wrn_off", 32'(bus.avm_write_n),    32'd1);
        chk("wr_cs_off",  32'(bus.avm_chipselect), 32'd0);
`ifdef DE2I_AVM_WRITE_ECHO_EN
        chk("wr_rspv_n2", 32'(bus.rsp_valid), 32'd0);
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'hA5A5_0001;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("wr_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("wr_rspd",  bus.rsp_data,       32'hA5A5_0001);
        chk("wr_rspe",  32'(bus.rsp_error), 32'd0);
        chk("wr_busy",  32'(bus.cmd_ready), 32'd0);
        tick();
        chk("wr_ready_back", 32'(bus.cmd_ready), 32'd1);
`else
        chk("wr_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("wr_rspd",  bus.rsp_data,       32'd0);
        chk("wr_rspe",  32'(bus.rsp_error), 32'd0);
        chk("wr_busy",  32'(bus.cmd_ready), 32'd0);
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'hFFFF_FFFF;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("wr_rspv_once",  32'(bus.rsp_valid), 32'd0);
        chk("wr_ready_back", 32'(bus.cmd_ready), 32'd1);
        chk("wr_rspd_keep",  bus.rsp_data,       32'd0);
`endif
        tick();

        // Read address 2: waitrequest for 3 cycles, data 2 cycles after completion
        bus.avm_waitrequest = 1'b1;
        issue(1'b0, 2'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_hold_rdn",  32'(bus.avm_read_n),     32'd0);
            chk("rd_hold_cs",   32'(bus.avm_chipselect), 32'd1);
            chk("rd_hold_addr", 32'(bus.avm_address),    32'd2);
            tick();
        end
        bus.avm_waitrequest = 1'b0;
        chk("rd_last_rdn",  32'(bus.avm_read_n),  32'd0);
        chk("rd_last_addr", 32'(bus.avm_address), 32'd2);
        tick();
        chk("rd_rdn_off",   32'(bus.avm_read_n),     32'd1);
        chk("rd_cs_off",    32'(bus.avm_chipselect), 32'd0);
        chk("rd_rspv_lat1", 32'(bus.rsp_valid),      32'd0);
        tick();
        chk("rd_rspv_lat2", 32'(bus.rsp_valid), 32'd0);
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'h1234_5678;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("rd_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("rd_rspd",  bus.rsp_data,       32'h1234_5678);
        chk("rd_rspe",  32'(bus.rsp_error), 32'd0);
        chk("rd_busy",  32'(bus.cmd_ready), 32'd0);
        tick();
        chk("rd_rspv_once", 32'(bus.rsp_valid), 32'd0);
        chk("rd_ready",     32'(bus.cmd_ready), 32'd1);

        // Read that the slave never answers: response 9 cycles after REQ entry
        issue(1'b0, 2'd1, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            chk("to_quiet", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("to_rspv", 32'(bus.rsp_valid),      32'd1);
        chk("to_rspe", 32'(bus.rsp_error),      32'd1);
        chk("to_rspd", bus.rsp_data,            32'd0);
        chk("to_cs",   32'(bus.avm_chipselect), 32'd0);
        chk("to_rdn",  32'(bus.avm_read_n),     32'd1);
        tick();
        chk("to_rspv_once", 32'(bus.rsp_valid),      32'd0);
        chk("to_ready",     32'(bus.cmd_ready),      32'd1);
        chk("to_idle_cs",   32'(bus.avm_chipselect), 32'd0);
        chk("to_idle_wrn",  32'(bus.avm_write_n),    32'd1);

        // Reset asserted during WAIT, late data afterwards, then a normal read
        issue(1'b0, 2'd3, 32'd0);
        tick();
        chk("mid_busy", 32'(bus.cmd_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_values("mid_rst");
        #2;
        reset_n = 1'b1;
        tick();
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'h5555_5555;
        tick();
        bus.avm_readdata_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("mid_ready",  32'(bus.cmd_ready), 32'd1);
            tick();
        end
        issue(1'b0, 2'd1, 32'd0);
        chk("post_rdn",  32'(bus.avm_read_n),  32'd0);
        chk("post_addr", 32'(bus.avm_address), 32'd1);
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'hCAFE_F00D;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("post_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("post_rspd", bus.rsp_data,       32'hCAFE_F00D);
        chk("post_rspe", 32'(bus.rsp_error), 32'd0);
        tick();
        chk("post_ready", 32'(bus.cmd_ready), 32'd1);

        // Stray readdata_valid in IDLE, then a read; busy commands are ignored
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'hDEAD_BEEF;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("stray_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_ready",  32'(bus.cmd_ready), 32'd1);
        issue(1'b0, 2'd2, 32'd0);
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = 1'b1;
        bus.cmd_writedata = 32'h7777_7777;
        chk("st_busy1", 32'(bus.cmd_ready),   32'd0);
        chk("st_rdn",   32'(bus.avm_read_n),  32'd0);
        chk("st_wrn",   32'(bus.avm_write_n), 32'd1);
        tick();
        chk("st_busy2",   32'(bus.cmd_ready),   32'd0);
        chk("st_wrn_off", 32'(bus.avm_write_n), 32'd1);
        chk("st_rspv0",   32'(bus.rsp_valid),   32'd0);
        bus.avm_readdata_valid = 1'b1;
        bus.avm_readdata       = 32'h0BAD_C0DE;
        tick();
        bus.avm_readdata_valid = 1'b0;
        chk("st_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("st_rspd",  bus.rsp_data,       32'h0BAD_C0DE);
        chk("st_busy3", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        tick();
        chk("st_ready",  32'(bus.cmd_ready),   32'd1);
        chk("st_rspv1",  32'(bus.rsp_valid),   32'd0);
        chk("st_wrn_id", 32'(bus.avm_write_n), 32'd1);
        chk("st_cs_id",  32'(bus.avm_chipselect), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
